// File: rtl/bso_count_ctrl.sv
// Ball/strike/out scoreboard core: turns edge-qualified button events into the
// count, outs, half-inning and inning shown by the display drivers.
module bso_count_ctrl #(
  parameter int MAX_INNING = 9,
  parameter int INN_W      = 4
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iBALL,
  input  logic             iSTRIKE,
  input  logic             iFOUL,
  input  logic             iOUT,
  output logic [1:0]       oBALL,
  output logic [1:0]       oSTRIKE,
  output logic [1:0]       oOUTS,
  output logic [INN_W-1:0] oINNING,
  output logic             oHALF,
  output logic             oWALK,
  output logic             oKOUT,
  output logic             oSIDE,
  output logic             oGAME_OVER
);

  localparam logic [INN_W-1:0] LastInning = INN_W'(MAX_INNING);

  logic prevBall, prevStrike, prevFoul, prevOut;
  logic evBall, evStrike, evFoul, evOut;

  logic [1:0]       ballNext, strikeNext, outsNext;
  logic [INN_W-1:0] inningNext;
  logic             halfNext, walkNext, koutNext, sideNext, gameOverNext;
  logic             outInc;

  assign evBall   = iBALL   & ~prevBall;
  assign evStrike = iSTRIKE & ~prevStrike;
  assign evFoul   = iFOUL   & ~prevFoul;
  assign evOut    = iOUT    & ~prevOut;

  always_comb begin
    ballNext     = oBALL;
    strikeNext   = oSTRIKE;
    outsNext     = oOUTS;
    inningNext   = oINNING;
    halfNext     = oHALF;
    gameOverNext = oGAME_OVER;
    walkNext     = 1'b0;
    koutNext     = 1'b0;
    sideNext     = 1'b0;
    outInc       = 1'b0;

    if (!oGAME_OVER) begin
      // Only the highest-priority event acts; the rest are dropped.
      if (evOut) begin
        ballNext   = 2'd0;
        strikeNext = 2'd0;
        outInc     = 1'b1;
      end else if (evStrike) begin
        if (oSTRIKE < 2'd2) begin
          strikeNext = oSTRIKE + 2'd1;
        end else begin
          ballNext   = 2'd0;
          strikeNext = 2'd0;
          koutNext   = 1'b1;
          outInc     = 1'b1;
        end
      end else if (evFoul) begin
        if (oSTRIKE < 2'd2) strikeNext = oSTRIKE + 2'd1;
      end else if (evBall) begin
        if (oBALL < 2'd3) begin
          ballNext = oBALL + 2'd1;
        end else begin
          ballNext   = 2'd0;
          strikeNext = 2'd0;
          walkNext   = 1'b1;
        end
      end

      if (outInc) begin
        if (oOUTS < 2'd2) begin
          outsNext = oOUTS + 2'd1;
        end else begin
          outsNext = 2'd0;
          sideNext = 1'b1;
          if (!oHALF) begin
            halfNext = 1'b1;
          end else if (oINNING < LastInning) begin
            halfNext   = 1'b0;
            inningNext = oINNING + 1'b1;
          end else begin
            gameOverNext = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      // History regs start high so a button held through reset never counts.
      prevBall   <= 1'b1;
      prevStrike <= 1'b1;
      prevFoul   <= 1'b1;
      prevOut    <= 1'b1;
      oBALL      <= 2'd0;
      oSTRIKE    <= 2'd0;
      oOUTS      <= 2'd0;
      oINNING    <= INN_W'(1);
      oHALF      <= 1'b0;
      oWALK      <= 1'b0;
      oKOUT      <= 1'b0;
      oSIDE      <= 1'b0;
      oGAME_OVER <= 1'b0;
    end else begin
      prevBall   <= iBALL;
      prevStrike <= iSTRIKE;
      prevFoul   <= iFOUL;
      prevOut    <= iOUT;
      oBALL      <= ballNext;
      oSTRIKE    <= strikeNext;
      oOUTS      <= outsNext;
      oINNING    <= inningNext;
      oHALF      <= halfNext;
      oWALK      <= walkNext;
      oKOUT      <= koutNext;
      oSIDE      <= sideNext;
      oGAME_OVER <= gameOverNext;
    end
  end

endmodule

// File: tb/tb_bso_count_ctrl.sv
// Scoreboard bench for bso_count_ctrl: each driven cycle queues its expected
// outputs, which are popped and compared once the DUT has clocked them out.
module tb_bso_count_ctrl;

  localparam int MAXI = 2;
  localparam int IW   = 4;

  localparam logic [3:0] EV_B = 4'b0001;
  localparam logic [3:0] EV_F = 4'b0010;
  localparam logic [3:0] EV_S = 4'b0100;
  localparam logic [3:0] EV_O = 4'b1000;
  localparam logic [3:0] EV_0 = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iBall = 1'b0, iStrike = 1'b0, iFoul = 1'b0, iOut = 1'b0;
  logic [1:0]    oBall, oStrike, oOuts;
  logic [IW-1:0] oInning;
  logic          oHalf, oWalk, oKout, oSide, oGameOver;

  typedef struct packed {
    logic [1:0]    b;
    logic [1:0]    s;
    logic [1:0]    o;
    logic [IW-1:0] inn;
    logic          half;
    logic          walk;
    logic          kout;
    logic          side;
    logic          go;
  } exp_t;

  exp_t expQ[$];
  int   vecCnt = 0;
  int   errCnt = 0;
  int   stepNo = 0;

  bso_count_ctrl #(.MAX_INNING(MAXI), .INN_W(IW)) dut (
    .iCLK(clk), .iRST(rst),
    .iBALL(iBall), .iSTRIKE(iStrike), .iFOUL(iFoul), .iOUT(iOut),
    .oBALL(oBall), .oSTRIKE(oStrike), .oOUTS(oOuts), .oINNING(oInning),
    .oHALF(oHalf), .oWALK(oWalk), .oKOUT(oKout), .oSIDE(oSide),
    .oGAME_OVER(oGameOver)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecCnt++;
    if (got !== want) begin
      errCnt++;
      $display("FAIL step %0d %s: got %0d, expected %0d", stepNo, tag, got, want);
    end
  endtask

  function automatic exp_t mk(input int b, input int s, input int o, input int inn,
                              input int half, input int walk, input int kout,
                              input int side, input int go);
    exp_t e;
    e.b    = 2'(b);
    e.s    = 2'(s);
    e.o    = 2'(o);
    e.inn  = IW'(inn);
    e.half = 1'(half);
    e.walk = 1'(walk);
    e.kout = 1'(kout);
    e.side = 1'(side);
    e.go   = 1'(go);
    return e;
  endfunction

  task automatic compareOut();
    exp_t e;
    if (expQ.size() == 0) begin
      checkVal("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = expQ.pop_front();
    checkVal("ball",     32'(oBall),     32'(e.b));
    checkVal("strike",   32'(oStrike),   32'(e.s));
    checkVal("outs",     32'(oOuts),     32'(e.o));
    checkVal("inning",   32'(oInning),   32'(e.inn));
    checkVal("half",     32'(oHalf),     32'(e.half));
    checkVal("walk",     32'(oWalk),     32'(e.walk));
    checkVal("kout",     32'(oKout),     32'(e.kout));
    checkVal("side",     32'(oSide),     32'(e.side));
    checkVal("gameover", 32'(oGameOver), 32'(e.go));
    $display("step %0d rst=%b ev(osfb)=%b%b%b%b -> b=%0d s=%0d o=%0d inn=%0d half=%b walk=%b kout=%b side=%b go=%b",
             stepNo, rst, iOut, iStrike, iFoul, iBall, oBall, oStrike, oOuts, oInning,
             oHalf, oWalk, oKout, oSide, oGameOver);
  endtask

  task automatic step(input logic r, input logic [3:0] ev, input exp_t e);
    stepNo++;
    rst = r;
    {iOut, iStrike, iFoul, iBall} = ev;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    compareOut();
  endtask

  // One-cycle pulse followed by one idle cycle, where pulses must be gone.
  task automatic pulse(input logic [3:0] ev, input exp_t e);
    exp_t idle;
    step(1'b0, ev, e);
    idle = e;
    idle.walk = 1'b0;
    idle.kout = 1'b0;
    idle.side = 1'b0;
    step(1'b0, EV_0, idle);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t rstE;
    rstE = mk(0,0,0,1,0,0,0,0,0);

    // iOUT held high through reset and after it: must not count
    step(1'b1, EV_O, rstE);
    step(1'b1, EV_O, rstE);
    step(1'b0, EV_O, rstE);
    step(1'b0, EV_O, rstE);
    step(1'b0, EV_0, rstE);

    // four balls -> walk
    pulse(EV_B, mk(1,0,0,1,0,0,0,0,0));
    pulse(EV_B, mk(2,0,0,1,0,0,0,0,0));
    pulse(EV_B, mk(3,0,0,1,0,0,0,0,0));
    pulse(EV_B, mk(0,0,0,1,0,1,0,0,0));

    // strikes and fouls -> strikeout
    pulse(EV_S, mk(0,1,0,1,0,0,0,0,0));
    pulse(EV_S, mk(0,2,0,1,0,0,0,0,0));
    for (int i = 0; i < 3; i++) pulse(EV_F, mk(0,2,0,1,0,0,0,0,0));
    pulse(EV_S, mk(0,0,1,1,0,0,1,0,0));

    // 2-1 count, then simultaneous ball+strike+out: out wins
    pulse(EV_B, mk(1,0,1,1,0,0,0,0,0));
    pulse(EV_B, mk(2,0,1,1,0,0,0,0,0));
    pulse(EV_S, mk(2,1,1,1,0,0,0,0,0));
    pulse(EV_B | EV_S | EV_O, mk(0,0,2,1,0,0,0,0,0));

    // iOUT held 5 cycles: a single out (the third, so side retires)
    step(1'b0, EV_O, mk(0,0,0,1,1,0,0,1,0));
    for (int i = 0; i < 4; i++) step(1'b0, EV_O, mk(0,0,0,1,1,0,0,0,0));
    step(1'b0, EV_0, mk(0,0,0,1,1,0,0,0,0));

    // reset, then six outs: top1 -> bot1 -> top2
    step(1'b1, EV_0, rstE);
    step(1'b0, EV_0, rstE);
    pulse(EV_O, mk(0,0,1,1,0,0,0,0,0));
    pulse(EV_O, mk(0,0,2,1,0,0,0,0,0));
    pulse(EV_O, mk(0,0,0,1,1,0,0,1,0));
    pulse(EV_O, mk(0,0,1,1,1,0,0,0,0));
    pulse(EV_O, mk(0,0,2,1,1,0,0,0,0));
    pulse(EV_O, mk(0,0,0,2,0,0,0,1,0));

    // top 2, then bottom 2 ending on a strikeout for the final out
    pulse(EV_O, mk(0,0,1,2,0,0,0,0,0));
    pulse(EV_O, mk(0,0,2,2,0,0,0,0,0));
    pulse(EV_O, mk(0,0,0,2,1,0,0,1,0));
    pulse(EV_O, mk(0,0,1,2,1,0,0,0,0));
    pulse(EV_O, mk(0,0,2,2,1,0,0,0,0));
    pulse(EV_S, mk(0,1,2,2,1,0,0,0,0));
    pulse(EV_S, mk(0,2,2,2,1,0,0,0,0));
    pulse(EV_S, mk(0,0,0,2,1,0,1,1,1));

    // game over: everything ignored
    pulse(EV_B, mk(0,0,0,2,1,0,0,0,1));
    pulse(EV_S, mk(0,0,0,2,1,0,0,0,1));
    pulse(EV_F, mk(0,0,0,2,1,0,0,0,1));
    pulse(EV_O, mk(0,0,0,2,1,0,0,0,1));

    // reset with a simultaneous ball edge: reset wins, held ball never counts
    step(1'b1, EV_B, rstE);
    step(1'b0, EV_B, rstE);
    step(1'b0, EV_0, rstE);
    pulse(EV_B, mk(1,0,0,1,0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
